// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared widths and state type for the memory write-back sequencer
package vec_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_addr_gen.sv
// rtl/wb_addr_gen.sv - loadable write-address up-counter with modulo wrap
//
// Purpose: holds the current write address; loads a base, increments by one per
//   accepted word, wraps from all-ones to zero.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset (count -> 0)
//   i_load  in   load i_base (has priority over i_inc)
//   i_base  in   value to load
//   i_inc   in   increment by one
//   o_addr  out  current address
module wb_addr_gen
  import vec_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_inc) begin
      // Natural overflow of the ADDR_W-bit add gives the wrap to zero.
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/mem_writeback_seq.sv
// rtl/mem_writeback_seq.sv - sequential data-memory writer for the processed word stream
//
// Purpose: accepts words over a valid/ready handshake and writes each one to data
//   memory at consecutive addresses starting from a base latched on start; pulses
//   done for one cycle at the end of the transfer.
// Optional feature macro: WB_CHECKSUM_EN (XOR checksum of written words; when
//   undefined, checksum is tied to 0).
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   launch a transfer (only honoured in IDLE)
//   base_addr  in   first write address, latched on start
//   length     in   word count, latched on start (0 = no writes, straight to done)
//   in_valid   in   upstream word valid
//   in_data    in   upstream word
//   in_ready   out  a word is accepted this cycle if in_valid is high
//   mem_we     out  registered memory write enable
//   mem_addr   out  registered memory write address
//   mem_wdata  out  registered memory write data
//   busy       out  high while writing
//   done       out  one-cycle end-of-transfer pulse
//   checksum   out  XOR of words written in the current/last transfer
module mem_writeback_seq
  import vec_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [ADDR_W-1:0] w_addr;
  logic              w_start_ok;
  logic              w_load;
  logic              w_xfer;
  logic              w_last;
  logic              w_in_ready;
  logic              w_busy;
  logic              w_done;

  // in_ready depends on state only, so w_xfer has no in_valid -> in_ready loop.
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_load     = w_start_ok && (length != '0);
  assign w_xfer     = (r_state == WRITE) && in_valid;
  assign w_last     = w_xfer && (r_remaining == LEN_W'(1));

  wb_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_base (base_addr),
    .i_inc  (w_xfer),
    .o_addr (w_addr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (length != '0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= w_xfer;
      if (w_load) begin
        r_remaining <= length;
      end else if (w_xfer) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      // Address/data only move on a transfer, so they hold while mem_we is low.
      if (w_xfer) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= in_data;
      end
    end
  end

`ifdef WB_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum ^ in_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign done      = w_done;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_writeback_seq.sv
// tb/tb_mem_writeback_seq.sv - self-checking bench for mem_writeback_seq
module tb_mem_writeback_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;

  mem_writeback_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] obs_addr[$];
  logic [15:0] obs_data[$];
  int          obs_cyc[$];
  int          done_cnt, done_cyc, busy_cnt, acc_cnt;
  logic        done_we;
  logic [15:0] done_cs;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_we  = mem_we;
      done_cs  = checksum;
    end
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    if (in_valid && in_ready === 1'b1) acc_cnt = acc_cnt + 1;
  end

  // Reference model: word i of a transfer lands at (base + i) mod 2**16.
  logic [15:0] tx_words[$];
  logic [15:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [15:0] exp_cs;
  int          start_cyc;

  function automatic void model(input logic [15:0] b, input int n);
    int unsigned a;
    exp_addr.delete();
    exp_data.delete();
    exp_cs = 16'h0000;
    for (int i = 0; i < n; i++) begin
      a = (int'(b) + i) % 65536;
      exp_addr.push_back(16'(a));
      exp_data.push_back(tx_words[i]);
`ifdef WB_CHECKSUM_EN
      exp_cs = exp_cs ^ tx_words[i];
`endif
    end
  endfunction

  function automatic void clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    acc_cnt  = 0;
    done_we  = 1'b0;
    done_cs  = 16'hxxxx;
  endfunction

  // mode 0: valid always high, 1: toggle 1,0,1,..., 2: random.
  task automatic run_xfer(input logic [15:0] b, input logic [15:0] n, input int mode,
                          input int stray_start_at);
    int idx = 0;
    int k = 0;
    logic v;
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n; in_valid = 1'b0;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom);
    length = 16'($urandom);
    while (done_cnt == 0 && k < 400) begin
      case (mode)
        0: v = 1'b1;
        1: v = (k % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = (idx < tx_words.size()) ? tx_words[idx] : 16'($urandom);
      start    = (k == stray_start_at);
      if (v && in_ready) idx++;
      k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (k >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no done within %0d cycles (base=%h len=%0d)", k, b, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b exp 0", mem_we); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_tests++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h exp 0000", mem_addr); end
    n_tests++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h exp 0000", mem_wdata); end
    n_tests++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL reset_checksum: got %h exp 0000", checksum); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    tx_words.delete();
    for (int i = 0; i < 4; i++) tx_words.push_back(16'h00A1 + 16'(i));
    model(16'h0010, 4);
    run_xfer(16'h0010, 16'd4, 0, -1);
    n_tests++; if (obs_addr.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d exp 4", obs_addr.size()); end
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL basic_write%0d: got %h/%h exp %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    if (obs_cyc.size() == 4) begin
      n_tests++;
      if (obs_cyc[3] - obs_cyc[0] != 3) begin n_fail++; $display("FAIL basic_consecutive: got span %0d exp 3", obs_cyc[3] - obs_cyc[0]); end
      n_tests++;
      if (done_cyc != obs_cyc[3] || done_we !== 1'b1) begin
        n_fail++; $display("FAIL basic_done_align: got done cyc %0d we %b exp cyc %0d we 1", done_cyc, done_we, obs_cyc[3]);
      end
      n_tests++;
      if (obs_cyc[0] != start_cyc + 2) begin n_fail++; $display("FAIL basic_latency: got first write cyc %0d exp %0d", obs_cyc[0], start_cyc + 2); end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d exp 1", done_cnt); end
    n_tests++; if (busy_cnt != 4) begin n_fail++; $display("FAIL basic_busy: got %0d cycles exp 4", busy_cnt); end
    n_tests++; if (done_cs !== exp_cs) begin n_fail++; $display("FAIL basic_checksum: got %h exp %h", done_cs, exp_cs); end
  endtask

  task automatic test_backpressure();
    logic [15:0] b;
    b = 16'($urandom);
    tx_words.delete();
    for (int i = 0; i < 3; i++) tx_words.push_back(16'($urandom));
    model(b, 3);
    run_xfer(b, 16'd3, 1, -1);
    n_tests++; if (obs_addr.size() != 3 || acc_cnt != 3) begin n_fail++; $display("FAIL gaps_count: got writes %0d accepts %0d exp 3/3", obs_addr.size(), acc_cnt); end
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL gaps_write%0d: got %h/%h exp %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    if (obs_cyc.size() == 3) begin
      n_tests++;
      if (obs_cyc[1] - obs_cyc[0] != 2 || obs_cyc[2] - obs_cyc[1] != 2) begin
        n_fail++; $display("FAIL gaps_spacing: got %0d,%0d exp 2,2", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
      end
    end
    n_tests++; if (done_cnt != 1 || done_we !== 1'b1) begin n_fail++; $display("FAIL gaps_done: got cnt %0d we %b exp 1/1", done_cnt, done_we); end
  endtask

  task automatic test_wrap();
    tx_words.delete();
    for (int i = 0; i < 4; i++) tx_words.push_back(16'($urandom));
    model(16'hFFFE, 4);
    run_xfer(16'hFFFE, 16'd4, 0, -1);
    n_tests++; if (obs_addr.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d exp 4", obs_addr.size()); end
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h exp %h", i, obs_addr[i], exp_addr[i]); end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL wrap_done: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_zero_len_and_ignored_start();
    logic [15:0] b;
    tx_words.delete();
    run_xfer(16'h1234, 16'd0, 0, -1);
    n_tests++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d exp 0", obs_addr.size()); end
    n_tests++; if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
      n_fail++; $display("FAIL zero_done: got cnt %0d cyc %0d exp 1 at %0d", done_cnt, done_cyc, start_cyc + 1);
    end
    n_tests++; if (busy_cnt != 0) begin n_fail++; $display("FAIL zero_busy: got %0d exp 0", busy_cnt); end
    b = 16'($urandom);
    for (int i = 0; i < 5; i++) tx_words.push_back(16'($urandom));
    model(b, 5);
    run_xfer(b, 16'd5, 0, 1);
    n_tests++; if (obs_addr.size() != 5) begin n_fail++; $display("FAIL stray_count: got %0d exp 5", obs_addr.size()); end
    for (int i = 0; i < 5 && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL stray_write%0d: got %h/%h exp %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL stray_done: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] b;
    b = 16'($urandom);
    tx_words.delete();
    for (int i = 0; i < 5; i++) tx_words.push_back(16'($urandom));
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = tx_words[0];
    @(posedge clk); #1;
    in_data = tx_words[1];
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got we %b busy %b rdy %b done %b exp all 0", mem_we, busy, in_ready, done);
    end
    n_tests++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || checksum !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_data: got %h/%h/%h exp 0000/0000/0000", mem_addr, mem_wdata, checksum);
    end
    repeat (6) @(posedge clk);
    #1;
    n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d exp 0", done_cnt); end
    n_tests++; if (obs_addr.size() != 2) begin n_fail++; $display("FAIL rst_mid_writes: got %0d exp 2", obs_addr.size()); end
    b = 16'($urandom);
    model(b, 5);
    run_xfer(b, 16'd5, 2, -1);
    n_tests++; if (obs_addr.size() != 5) begin n_fail++; $display("FAIL rst_restart_count: got %0d exp 5", obs_addr.size()); end
    for (int i = 0; i < 5 && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL rst_restart%0d: got %h/%h exp %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_checksum();
    logic [15:0] b;
    b = 16'($urandom);
    tx_words.delete();
    tx_words.push_back(16'h1234);
    tx_words.push_back(16'h00FF);
    tx_words.push_back(16'hF0F0);
    model(b, 3);
    run_xfer(b, 16'd3, 2, -1);
    n_tests++; if (done_cs !== exp_cs) begin n_fail++; $display("FAIL checksum_done: got %h exp %h", done_cs, exp_cs); end
    n_tests++; if (checksum !== exp_cs) begin n_fail++; $display("FAIL checksum_hold: got %h exp %h", checksum, exp_cs); end
  endtask

  task automatic test_random();
    logic [15:0] b;
    int n;
    for (int t = 0; t < 8; t++) begin
      b = 16'($urandom);
      n = $urandom_range(1, 9);
      tx_words.delete();
      for (int i = 0; i < n; i++) tx_words.push_back(16'($urandom));
      model(b, n);
      run_xfer(b, 16'(n), 2, -1);
      n_tests++; if (obs_addr.size() != n || acc_cnt != n) begin n_fail++; $display("FAIL rand%0d_count: got %0d/%0d exp %0d", t, obs_addr.size(), acc_cnt, n); end
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
        n_tests++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_fail++; $display("FAIL rand%0d_write%0d: got %h/%h exp %h/%h", t, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
      n_tests++; if (done_cnt != 1 || done_cs !== exp_cs) begin n_fail++; $display("FAIL rand%0d_done: got %0d cs %h exp 1 cs %h", t, done_cnt, done_cs, exp_cs); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len_and_ignored_start();
    test_reset_mid();
    test_checksum();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
